// File: rtl/branch_exec_unit.sv
// Branch/jump execution unit: resolves direction, target and link value in the
// first stage, then carries the result through a stallable, killable pipe.
module branch_exec_unit #(
   parameter int DATA_LEN   = 32,
   parameter int ADDR_LEN   = 32,
   parameter int TAG_W      = 6,
   parameter int PIPE_DEPTH = 2
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                issue_i,
   input  logic [3:0]          alu_op_i,
   input  logic [DATA_LEN-1:0] src1_i,
   input  logic [DATA_LEN-1:0] src2_i,
   input  logic [ADDR_LEN-1:0] pc_i,
   input  logic [DATA_LEN-1:0] imm_i,
   input  logic [TAG_W-1:0]    rrf_tag_i,
   input  logic                if_write_rrf_i,
   input  logic                pred_taken_i,
   input  logic [ADDR_LEN-1:0] pred_addr_i,
   input  logic                stall_i,
   input  logic                kill_i,
   output logic                ready_o,
   output logic                rob_we_o,
   output logic                rrf_we_o,
   output logic [TAG_W-1:0]    rrf_tag_o,
   output logic [DATA_LEN-1:0] result_o,
   output logic                brcond_o,
   output logic [ADDR_LEN-1:0] jmpaddr_o,
   output logic [ADDR_LEN-1:0] jmpaddr_taken_o,
   output logic                mispredict_o
);

   typedef enum logic [3:0] {
      OP_BEQ  = 4'd0,
      OP_BNE  = 4'd1,
      OP_BLT  = 4'd2,
      OP_BGE  = 4'd3,
      OP_BLTU = 4'd4,
      OP_BGEU = 4'd5,
      OP_JAL  = 4'd6,
      OP_JALR = 4'd7
   } op_e;

   typedef struct packed {
      logic                rrf_we;
      logic [TAG_W-1:0]    tag;
      logic [DATA_LEN-1:0] result;
      logic                brcond;
      logic [ADDR_LEN-1:0] jmpaddr;
      logic [ADDR_LEN-1:0] jmpaddr_taken;
      logic                mispredict;
   } payload_t;

   payload_t                comp;
   payload_t                pipe [PIPE_DEPTH];
   logic [PIPE_DEPTH-1:0]   valid;
   logic [PIPE_DEPTH-1:0]   hold;
   logic                    taken;
   logic                    is_jump;
   logic                    known_op;
   logic [ADDR_LEN-1:0]     pc_plus4;
   logic [ADDR_LEN-1:0]     target;

   always_comb begin
      taken    = 1'b0;
      is_jump  = 1'b0;
      known_op = 1'b1;
      case (alu_op_i)
         OP_BEQ:  taken = (src1_i == src2_i);
         OP_BNE:  taken = (src1_i != src2_i);
         OP_BLT:  taken = ($signed(src1_i) <  $signed(src2_i));
         OP_BGE:  taken = ($signed(src1_i) >= $signed(src2_i));
         OP_BLTU: taken = (src1_i <  src2_i);
         OP_BGEU: taken = (src1_i >= src2_i);
         OP_JAL, OP_JALR: begin
            taken   = 1'b1;
            is_jump = 1'b1;
         end
         default: known_op = 1'b0;
      endcase

      pc_plus4 = pc_i + ADDR_LEN'(4);
      if (alu_op_i == OP_JALR)
         target = (ADDR_LEN'(src1_i) + ADDR_LEN'(imm_i)) & {{(ADDR_LEN-1){1'b1}}, 1'b0};
      else
         target = pc_i + ADDR_LEN'(imm_i);

      // Unknown opcodes never flag a mispredict regardless of the prediction.
      comp               = '0;
      comp.rrf_we        = is_jump & if_write_rrf_i;
      comp.tag           = rrf_tag_i;
      comp.result        = is_jump ? DATA_LEN'(pc_plus4) : '0;
      comp.brcond        = taken;
      comp.jmpaddr       = taken ? target : pc_plus4;
      comp.jmpaddr_taken = target;
      comp.mispredict    = known_op & ((taken != pred_taken_i) |
                                       (taken & (pred_addr_i != target)));
   end

   // A stage freezes only if it and every stage after it are full under stall,
   // so bubbles ahead of a blocked entry keep collapsing.
   always_comb begin
      hold = '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
         logic h;
         h = stall_i;
         for (int j = 0; j < PIPE_DEPTH; j++)
            if (j >= i) h = h & valid[j];
         hold[i] = h;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         valid <= '0;
         for (int i = 0; i < PIPE_DEPTH; i++) pipe[i] <= '0;
      end else begin
         if (!hold[0]) begin
            valid[0] <= issue_i & ~kill_i;
            if (issue_i & ~kill_i) pipe[0] <= comp;
         end
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            if (!hold[i]) begin
               valid[i] <= valid[i-1];
               if (valid[i-1]) pipe[i] <= pipe[i-1];
            end
         end
         if (kill_i) valid <= '0;
      end
   end

   assign ready_o         = ~hold[0];
   assign rob_we_o        = valid[PIPE_DEPTH-1] & ~kill_i;
   assign rrf_we_o        = rob_we_o & pipe[PIPE_DEPTH-1].rrf_we;
   assign mispredict_o    = rob_we_o & pipe[PIPE_DEPTH-1].mispredict;
   assign rrf_tag_o       = pipe[PIPE_DEPTH-1].tag;
   assign result_o        = pipe[PIPE_DEPTH-1].result;
   assign brcond_o        = pipe[PIPE_DEPTH-1].brcond;
   assign jmpaddr_o       = pipe[PIPE_DEPTH-1].jmpaddr;
   assign jmpaddr_taken_o = pipe[PIPE_DEPTH-1].jmpaddr_taken;

endmodule

// File: tb/tb_branch_exec_unit.sv
// Bench for branch_exec_unit: directed vector table, stall/kill/reset sequences,
// and random traffic scored against an in-order expected-result queue.
module tb_branch_exec_unit;

   localparam int D = 2;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        issue_i;
   logic [3:0]  alu_op_i;
   logic [31:0] src1_i, src2_i, pc_i, imm_i, pred_addr_i;
   logic [5:0]  rrf_tag_i;
   logic        if_write_rrf_i, pred_taken_i, stall_i, kill_i;
   logic        ready_o, rob_we_o, rrf_we_o, brcond_o, mispredict_o;
   logic [5:0]  rrf_tag_o;
   logic [31:0] result_o, jmpaddr_o, jmpaddr_taken_o;

   always #5 clk_i = ~clk_i;

   branch_exec_unit #(.DATA_LEN(32), .ADDR_LEN(32), .TAG_W(6), .PIPE_DEPTH(D)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .issue_i(issue_i), .alu_op_i(alu_op_i),
      .src1_i(src1_i), .src2_i(src2_i), .pc_i(pc_i), .imm_i(imm_i),
      .rrf_tag_i(rrf_tag_i), .if_write_rrf_i(if_write_rrf_i),
      .pred_taken_i(pred_taken_i), .pred_addr_i(pred_addr_i),
      .stall_i(stall_i), .kill_i(kill_i), .ready_o(ready_o), .rob_we_o(rob_we_o),
      .rrf_we_o(rrf_we_o), .rrf_tag_o(rrf_tag_o), .result_o(result_o),
      .brcond_o(brcond_o), .jmpaddr_o(jmpaddr_o), .jmpaddr_taken_o(jmpaddr_taken_o),
      .mispredict_o(mispredict_o)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] src1, src2, pc, imm;
      logic [5:0]  tag;
      logic        wr, pt;
      logic [31:0] pa;
   } vec_t;

   typedef struct packed {
      logic        rrf_we;
      logic [5:0]  tag;
      logic [31:0] result;
      logic        brcond;
      logic [31:0] jmpaddr;
      logic [31:0] jtaken;
      logic        mis;
   } exp_t;

   typedef struct {
      vec_t        v;
      logic        brcond;
      logic [31:0] jmpaddr, result;
      logic        rrf_we, mis;
   } dir_t;

   int   checks   = 0;
   int   failures = 0;
   int   pulses   = 0;
   exp_t sb_q[$];
   bit   nop_q[$];
   vec_t zero_v;

   function automatic vec_t mkv(logic [3:0] op, logic [31:0] s1, logic [31:0] s2,
                                logic [31:0] pc, logic [31:0] imm, logic [5:0] tag,
                                logic wr, logic pt, logic [31:0] pa);
      vec_t v;
      v.op = op; v.src1 = s1; v.src2 = s2; v.pc = pc; v.imm = imm;
      v.tag = tag; v.wr = wr; v.pt = pt; v.pa = pa;
      return v;
   endfunction

   function automatic dir_t mk(vec_t v, logic bc, logic [31:0] ja, logic [31:0] res,
                               logic rw, logic mis);
      dir_t d;
      d.v = v; d.brcond = bc; d.jmpaddr = ja; d.result = res; d.rrf_we = rw; d.mis = mis;
      return d;
   endfunction

   // Reference behaviour: signed order via sign-bit flip, plain 32-bit wraparound sums.
   function automatic exp_t ref_model(vec_t v);
      exp_t        e;
      logic        taken, jump;
      logic [31:0] tgt, seq;
      seq  = v.pc + 32'd4;
      tgt  = (v.op == 4'd7) ? ((v.src1 + v.imm) & 32'hFFFF_FFFE) : (v.pc + v.imm);
      jump = (v.op == 4'd6) || (v.op == 4'd7);
      case (v.op)
         4'd0: taken = (v.src1 == v.src2);
         4'd1: taken = (v.src1 != v.src2);
         4'd2: taken = (v.src1 ^ 32'h8000_0000) <  (v.src2 ^ 32'h8000_0000);
         4'd3: taken = (v.src1 ^ 32'h8000_0000) >= (v.src2 ^ 32'h8000_0000);
         4'd4: taken = v.src1 <  v.src2;
         4'd5: taken = v.src1 >= v.src2;
         4'd6, 4'd7: taken = 1'b1;
         default: taken = 1'b0;
      endcase
      e.rrf_we  = jump && v.wr;
      e.tag     = v.tag;
      e.result  = jump ? seq : 32'd0;
      e.brcond  = taken;
      e.jmpaddr = taken ? tgt : seq;
      e.jtaken  = tgt;
      e.mis     = (v.op <= 4'd7) && ((taken != v.pt) || (taken && (v.pa != tgt)));
      return e;
   endfunction

   task automatic drive(input vec_t v, input logic iss, input logic st, input logic kl);
      issue_i = iss; alu_op_i = v.op; src1_i = v.src1; src2_i = v.src2;
      pc_i = v.pc; imm_i = v.imm; rrf_tag_i = v.tag; if_write_rrf_i = v.wr;
      pred_taken_i = v.pt; pred_addr_i = v.pa; stall_i = st; kill_i = kl;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_rob_we"},  32'(rob_we_o), 32'd0);
      checkOutput({tag, "_rrf_we"},  32'(rrf_we_o), 32'd0);
      checkOutput({tag, "_brcond"},  32'(brcond_o), 32'd0);
      checkOutput({tag, "_mispred"}, 32'(mispredict_o), 32'd0);
      checkOutput({tag, "_tag"},     32'(rrf_tag_o), 32'd0);
      checkOutput({tag, "_result"},  result_o, 32'd0);
      checkOutput({tag, "_jmpaddr"}, jmpaddr_o, 32'd0);
      checkOutput({tag, "_jtaken"},  jmpaddr_taken_o, 32'd0);
   endtask

   // One clock of traffic: drive after the edge, score at the falling edge.
   task automatic step(input logic iss, input vec_t v, input logic st, input logic kl);
      logic exp_ready;
      exp_t act, ex;
      @(posedge clk_i); #1;
      drive(v, iss, st, kl);
      @(negedge clk_i);
      exp_ready = !(sb_q.size() == D && st);
      checkOutput("ready", 32'(ready_o), 32'(exp_ready));
      if (kl) checkOutput("kill_rob_we", 32'(rob_we_o), 32'd0);
      if (rob_we_o) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL spurious_result: got rob_we=1, expected no result pending");
         end else begin
            act = {rrf_we_o, rrf_tag_o, result_o, brcond_o, jmpaddr_o, jmpaddr_taken_o, mispredict_o};
            ex  = sb_q[0];
            if (nop_q[0]) begin
               act.jtaken = '0;
               ex.jtaken  = '0;
            end
            if (act !== ex) begin
               failures++;
               $display("[TB] FAIL scoreboard: got %h, expected %h", act, ex);
            end
            if (!st) begin
               void'(sb_q.pop_front());
               void'(nop_q.pop_front());
               pulses++;
            end
         end
      end
      if (kl) begin
         sb_q.delete();
         nop_q.delete();
      end else if (iss && exp_ready) begin
         sb_q.push_back(ref_model(v));
         nop_q.push_back(v.op > 4'd7);
      end
   endtask

   task automatic applyStimulus(input int idx, input dir_t d);
      @(posedge clk_i); #1;
      drive(d.v, 1'b1, 1'b0, 1'b0);
      @(posedge clk_i); #1;
      issue_i = 1'b0;
      for (int k = 0; k < D - 1; k++) begin
         @(negedge clk_i);
         checkOutput($sformatf("vec%0d_early_rob_we", idx), 32'(rob_we_o), 32'd0);
         @(posedge clk_i);
      end
      @(negedge clk_i);
      checkOutput($sformatf("vec%0d_rob_we", idx),  32'(rob_we_o), 32'd1);
      checkOutput($sformatf("vec%0d_brcond", idx),  32'(brcond_o), 32'(d.brcond));
      checkOutput($sformatf("vec%0d_jmpaddr", idx), jmpaddr_o, d.jmpaddr);
      checkOutput($sformatf("vec%0d_result", idx),  result_o, d.result);
      checkOutput($sformatf("vec%0d_rrf_we", idx),  32'(rrf_we_o), 32'(d.rrf_we));
      checkOutput($sformatf("vec%0d_tag", idx),     32'(rrf_tag_o), 32'(d.v.tag));
      checkOutput($sformatf("vec%0d_mispred", idx), 32'(mispredict_o), 32'(d.mis));
      @(negedge clk_i);
      checkOutput($sformatf("vec%0d_single_pulse", idx), 32'(rob_we_o), 32'd0);
   endtask

   // Issuing into a full, stalled unit is a protocol violation.
   always @(posedge clk_i) begin
      if (!reset_i && issue_i && !ready_o) begin
         failures++;
         $display("[TB] FAIL protocol: got issue while ready=0, expected no issue");
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      dir_t dirs[18];
      vec_t seqv[4];
      vec_t rv;
      exp_t re;
      int   sent;
      logic st, kl, iss;

      zero_v = mkv(4'd0, 0, 0, 0, 0, 0, 0, 0, 0);
      dirs[0]  = mk(mkv(4'd0, 5, 5, 32'h100, 32'h20, 1, 0, 1, 32'h120), 1, 32'h120, 0, 0, 0);
      dirs[1]  = mk(mkv(4'd2, 32'hFFFF_FFFF, 1, 32'h300, 32'h40, 2, 0, 1, 32'h340), 1, 32'h340, 0, 0, 0);
      dirs[2]  = mk(mkv(4'd4, 32'hFFFF_FFFF, 1, 32'h300, 32'h40, 2, 0, 1, 32'h340), 0, 32'h304, 0, 0, 1);
      dirs[3]  = mk(mkv(4'd4, 32'hFFFF_FFFF, 1, 32'h300, 32'h40, 2, 0, 0, 32'h340), 0, 32'h304, 0, 0, 0);
      dirs[4]  = mk(mkv(4'd7, 32'h1001, 0, 32'h200, 2, 9, 1, 1, 32'h1002), 1, 32'h1002, 32'h204, 1, 0);
      dirs[5]  = mk(mkv(4'd6, 0, 0, 32'h400, 32'hFFFF_FFF0, 3, 1, 1, 32'h3F0), 1, 32'h3F0, 32'h404, 1, 0);
      dirs[6]  = mk(mkv(4'd6, 0, 0, 32'h400, 32'hFFFF_FFF0, 3, 1, 1, 32'h3F4), 1, 32'h3F0, 32'h404, 1, 1);
      dirs[7]  = mk(mkv(4'd1, 7, 7, 32'h500, 8, 4, 0, 1, 32'h508), 0, 32'h504, 0, 0, 1);
      dirs[8]  = mk(mkv(4'd3, 32'h8000_0000, 1, 32'h600, 32'h10, 5, 0, 0, 0), 0, 32'h604, 0, 0, 0);
      dirs[9]  = mk(mkv(4'd5, 32'h8000_0000, 1, 32'h700, 32'h10, 6, 0, 1, 32'h710), 1, 32'h710, 0, 0, 0);
      dirs[10] = mk(mkv(4'd9, 3, 3, 32'h800, 32'h10, 7, 1, 1, 32'h810), 0, 32'h804, 0, 0, 0);
      dirs[11] = mk(mkv(4'd0, 0, 0, 32'hFFFF_FFFC, 8, 8, 0, 1, 4), 1, 32'h4, 0, 0, 0);
      dirs[12] = mk(mkv(4'd1, 0, 0, 32'hFFFF_FFFC, 8, 10, 0, 0, 0), 0, 32'h0, 0, 0, 0);
      dirs[13] = mk(mkv(4'd6, 0, 0, 32'h900, 32'h100, 11, 0, 1, 32'hA00), 1, 32'hA00, 32'h904, 0, 0);
      dirs[14] = mk(mkv(4'd0, 5, 5, 32'h100, 32'h20, 12, 0, 1, 32'h124), 1, 32'h120, 0, 0, 1);
      dirs[15] = mk(mkv(4'd3, 1, 32'hFFFF_FFFF, 32'h1000, 32'h20, 13, 0, 0, 0), 1, 32'h1020, 0, 0, 1);
      dirs[16] = mk(mkv(4'd15, 1, 2, 32'h40, 32'h8, 13, 1, 0, 0), 0, 32'h44, 0, 0, 0);
      dirs[17] = mk(mkv(4'd7, 32'h2000, 0, 32'h300, 32'hFFFF_FFFF, 14, 1, 0, 0), 1, 32'h1FFE, 32'h304, 1, 1);

      reset_i = 1'b1;
      drive(zero_v, 1'b0, 1'b0, 1'b0);
      #3;
      checkAllZero("reset");
      checkOutput("reset_ready", 32'(ready_o), 32'd1);
      @(posedge clk_i); @(posedge clk_i); #2;
      reset_i = 1'b0;

      $display("[TB] directed vectors");
      for (int i = 0; i < 18; i++) applyStimulus(i, dirs[i]);

      $display("[TB] back-to-back issues with stall");
      seqv[0] = mkv(4'd6, 0, 0, 32'h1000, 32'h40, 21, 1, 1, 32'h1040);
      seqv[1] = mkv(4'd0, 3, 4, 32'h1004, 32'h80, 22, 0, 0, 0);
      seqv[2] = mkv(4'd2, 32'hFFFF_FFF0, 2, 32'h1008, 32'h10, 23, 0, 0, 0);
      seqv[3] = mkv(4'd7, 32'h3333, 0, 32'h100C, 32'h5, 24, 1, 1, 32'h3338);
      pulses = 0;
      sent   = 0;
      for (int k = 1; k <= 12; k++) begin
         st  = (k >= 2 && k <= 4);
         iss = (sent < 4) && !(sb_q.size() == D && st);
         step(iss, seqv[sent % 4], st, 1'b0);
         if (iss) sent++;
      end
      checkOutput("seq_pulses", 32'(pulses), 32'd4);
      checkOutput("seq_drained", 32'(sb_q.size()), 32'd0);

      $display("[TB] kill with entries in flight");
      step(1'b1, seqv[0], 1'b0, 1'b0);
      step(1'b1, seqv[1], 1'b0, 1'b0);
      pulses = 0;
      step(1'b1, seqv[3], 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) step(1'b0, zero_v, 1'b0, 1'b0);
      checkOutput("kill_pulses", 32'(pulses), 32'd0);

      $display("[TB] async reset mid-stream");
      step(1'b1, seqv[0], 1'b0, 1'b0);
      step(1'b1, seqv[3], 1'b0, 1'b0);
      step(1'b0, zero_v, 1'b1, 1'b0);
      checkOutput("pre_reset_rob_we", 32'(rob_we_o), 32'd1);
      #2;
      reset_i = 1'b1;
      #1;
      checkAllZero("async_reset");
      sb_q.delete();
      nop_q.delete();
      stall_i = 1'b0;
      @(posedge clk_i); @(posedge clk_i); #2;
      reset_i = 1'b0;
      pulses = 0;
      for (int k = 0; k < 6; k++) step(1'b0, zero_v, 1'b0, 1'b0);
      checkOutput("post_reset_pulses", 32'(pulses), 32'd0);

      $display("[TB] random traffic");
      for (int n = 0; n < 500; n++) begin
         rv.op   = 4'($urandom_range(0, 9));
         rv.src1 = $urandom;
         rv.src2 = ($urandom_range(0, 3) == 0) ? rv.src1 : $urandom;
         rv.pc   = $urandom & 32'hFFFF_FFFC;
         rv.imm  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
         rv.tag  = 6'($urandom_range(0, 63));
         rv.wr   = 1'($urandom_range(0, 1));
         rv.pt   = 1'($urandom_range(0, 1));
         re      = ref_model(rv);
         rv.pa   = ($urandom_range(0, 2) != 0) ? re.jtaken : re.jtaken + 32'd4;
         st      = ($urandom_range(0, 9) < 3);
         kl      = ($urandom_range(0, 49) == 0);
         iss     = ($urandom_range(0, 9) < 7) && !(sb_q.size() == D && st);
         step(iss, rv, st, kl);
      end
      for (int k = 0; k < 20 && sb_q.size() != 0; k++) step(1'b0, zero_v, 1'b0, 1'b0);
      checkOutput("random_drained", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_exec_unit.md
BRANCH_EXEC_UNIT -- requirements
Module: branch_exec_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL clear immediately on reset_i=1, independent of clk_i.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- DATA_LEN, 32, operand/result width.
- ADDR_LEN, 32, PC/target width.
- TAG_W, 6, rename (RRF) tag width.
- PIPE_DEPTH, 2, issue-to-result latency in cycles; legal values 1..4.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1, clock.
- reset_i, in, 1, async active-high reset.
- issue_i, in, 1, instruction valid.
- alu_op_i, in, 4, operation code.
- src1_i, in, DATA_LEN, operand 1.
- src2_i, in, DATA_LEN, operand 2.
- pc_i, in, ADDR_LEN, instruction PC.
- imm_i, in, DATA_LEN, sign-extended immediate.
- rrf_tag_i, in, TAG_W, destination tag.
- if_write_rrf_i, in, 1, instruction writes a register.
- pred_taken_i, in, 1, predicted direction.
- pred_addr_i, in, ADDR_LEN, predicted target.
- stall_i, in, 1, downstream backpressure.
- kill_i, in, 1, flush all in-flight entries.
- ready_o, out, 1, can accept an issue this cycle.
- rob_we_o, out, 1, result valid.
- rrf_we_o, out, 1, register write valid.
- rrf_tag_o, out, TAG_W, destination tag.
- result_o, out, DATA_LEN, link value.
- brcond_o, out, 1, resolved taken.
- jmpaddr_o, out, ADDR_LEN, resolved next PC.
- jmpaddr_taken_o, out, ADDR_LEN, target if taken.
- mispredict_o, out, 1, prediction wrong.

Function
REQ-004 alu_op_i encodings SHALL be: 0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU, 6 JAL, 7 JALR; all other encodings are NOP: not taken, no register write, never mispredicted.
REQ-005 Comparisons SHALL use signed compare for BLT/BGE and unsigned compare for BLTU/BGEU, over the full DATA_LEN.
REQ-006 jmpaddr_taken SHALL be pc_i+imm_i for branches and JAL, and (src1_i+imm_i) with bit 0 cleared for JALR; addition is modulo 2^ADDR_LEN.
REQ-007 brcond SHALL be 1 for JAL and JALR, and the compare result for branches.
REQ-008 jmpaddr_o SHALL be jmpaddr_taken_o when brcond_o=1, else pc+4 (modulo wrap).
REQ-009 result_o SHALL be pc+4 for JAL/JALR and 0 otherwise.
REQ-010 rrf_we_o SHALL equal rob_we_o & if_write_rrf & (op is JAL or JALR).
REQ-011 mispredict_o SHALL equal rob_we_o & ((brcond != pred_taken) | (brcond & pred_addr != jmpaddr_taken)).
REQ-012 Computation SHALL occur in the first stage; results SHALL then traverse PIPE_DEPTH-1 register stages, each holding a valid bit and a payload.
REQ-013 With no stall, an issue at edge N SHALL produce rob_we_o=1 for exactly one cycle, after edge N+PIPE_DEPTH-1 (PIPE_DEPTH=1: the cycle after the issue edge).
REQ-014 stall_i=1 SHALL freeze every stage that holds valid data downstream of a full stage; bubbles SHALL collapse; outputs SHALL hold while stalled; rob_we_o SHALL stay 1 until the first non-stalled cycle.
REQ-015 ready_o SHALL be 0 only when all stages are valid and stall_i=1.
REQ-016 issue_i while ready_o=0 SHALL be ignored (a protocol violation; a bench assertion flags it).
REQ-017 kill_i=1 SHALL clear all valid bits at the next edge and SHALL discard an issue in the same cycle; while kill_i=1, outputs SHALL be undriven-valid (rob_we_o, rrf_we_o, mispredict_o forced 0 combinationally).
REQ-018 Throughput SHALL be one instruction per cycle when unstalled.

Reset
REQ-019 On reset all valid bits, rob_we_o, rrf_we_o, brcond_o, and mispredict_o SHALL be 0, and all payload outputs SHALL be 0.
REQ-020 ready_o SHALL be 1 from the first cycle after reset deasserts.
REQ-021 Reset asserted mid-pipeline SHALL drop all in-flight entries; nothing SHALL emerge after reset is released.

Verification
REQ-022 PIPE_DEPTH=2, BEQ with src1=src2=5, pc=0x100, imm=0x20, pred_taken=1, pred_addr=0x120 -> two cycles later: rob_we_o=1, brcond_o=1, jmpaddr_o=0x120, mispredict_o=0.
REQ-023 BLT with src1=0xFFFFFFFF, src2=1 -> taken; BLTU with the same operands -> not taken, jmpaddr_o=pc+4; mispredict_o=1 whenever pred_taken differs.
REQ-024 JALR with src1=0x1001, imm=2, pc=0x200, if_write_rrf_i=1, tag 9 -> jmpaddr_o=0x1002, result_o=0x204, rrf_we_o=1, rrf_tag_o=9.
REQ-025 Four back-to-back issues with stall_i=1 for cycles 2-4 -> no loss or duplication, results exit in order, ready_o=0 only while full and stalled.
REQ-026 kill_i with 2 entries in flight plus a same-cycle issue -> zero rob_we_o pulses afterward; async reset mid-stream -> outputs go to 0 without waiting for a clock edge.
